// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
// State encodings, the state range macro and the default trap vector live here.
`ifndef PIPE_HAZARD_CTRL_PKG_SV
`define PIPE_HAZARD_CTRL_PKG_SV

`define PHC_STATE_RANGE 1:0

package pipe_hazard_ctrl_pkg;

    typedef enum logic [`PHC_STATE_RANGE] {
        ST_RUN           = 2'd0,
        ST_MC_WAIT       = 2'd1,
        ST_TRAP_DRAIN    = 2'd2,
        ST_TRAP_REDIRECT = 2'd3
    } state_e;

    localparam logic [31:0] TRAP_VECTOR_DEFAULT = 32'h0000_0004;

    // True when an ID source is actually read and matches the EX destination.
    function automatic logic src_hit(input logic rd, input logic [4:0] src, input logic [4:0] waddr);
        return rd && (src == waddr);
    endfunction

endpackage

`endif

// File: rtl/pipe_hazard_ctrl_if.sv
// Datapath <-> hazard controller signal bundle.
// The datapath uses the master modport; the controller uses the slave modport.
interface pipe_hazard_ctrl_if;
    logic [4:0]  id_rs1_addr;
    logic        id_rs1_rd;
    logic [4:0]  id_rs2_addr;
    logic        id_rs2_rd;
    logic [4:0]  id2ex_reg_waddr;
    logic        id2ex_reg_wen;
    logic        id2ex_mem_rd;
    logic [31:0] id2ex_pc;
    logic        ex_ill_instr;
    logic        ex_branch_taken;
    logic [31:0] ex_branch_target;
    logic        ex_mc_start;
    logic        ex_mc_done;
    logic        mem_stall;
    logic        if_stall;
    logic        if_flush;
    logic        id_flush;
    logic        ex_stall;
    logic        ex_flush;
    logic        pc_redirect;
    logic [31:0] pc_target;
    logic [31:0] trap_pc;
    logic        trap_active;
    logic [31:0] perf_stall_cnt;
    logic [31:0] perf_flush_cnt;
    logic [31:0] perf_trap_cnt;

    modport master (
        output id_rs1_addr, id_rs1_rd, id_rs2_addr, id_rs2_rd,
               id2ex_reg_waddr, id2ex_reg_wen, id2ex_mem_rd, id2ex_pc,
               ex_ill_instr, ex_branch_taken, ex_branch_target,
               ex_mc_start, ex_mc_done, mem_stall,
        input  if_stall, if_flush, id_flush, ex_stall, ex_flush,
               pc_redirect, pc_target, trap_pc, trap_active,
               perf_stall_cnt, perf_flush_cnt, perf_trap_cnt
    );

    modport slave (
        input  id_rs1_addr, id_rs1_rd, id_rs2_addr, id_rs2_rd,
               id2ex_reg_waddr, id2ex_reg_wen, id2ex_mem_rd, id2ex_pc,
               ex_ill_instr, ex_branch_taken, ex_branch_target,
               ex_mc_start, ex_mc_done, mem_stall,
        output if_stall, if_flush, id_flush, ex_stall, ex_flush,
               pc_redirect, pc_target, trap_pc, trap_active,
               perf_stall_cnt, perf_flush_cnt, perf_trap_cnt
    );
endinterface

// File: rtl/pipe_hazard_ctrl_perf_cnt.sv
// hazard_perf_cnt: three free-running event counters (stall, flush, trap), wrapping at 2^32.
// Only instantiated when CORE_HAZARD_PERF_EN is defined.
module hazard_perf_cnt (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_evt,
    input  logic        flush_evt,
    input  logic        trap_evt,
    output logic [31:0] stall_cnt,
    output logic [31:0] flush_cnt,
    output logic [31:0] trap_cnt
);
    logic [2:0] evt;
    assign evt = {trap_evt, flush_evt, stall_evt};

    for (genvar gi = 0; gi < 3; gi++) begin : g_cnt
        logic [31:0] cnt_reg;
        always_ff @(posedge clk) begin
            if (rst)
                cnt_reg <= '0;
            else if (evt[gi])
                cnt_reg <= cnt_reg + 32'd1;
        end
    end

    assign stall_cnt = g_cnt[0].cnt_reg;
    assign flush_cnt = g_cnt[1].cnt_reg;
    assign trap_cnt  = g_cnt[2].cnt_reg;
endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: load-use stalls, branch flushes, multi-cycle waits, trap entry.
// Performance counters exist only when CORE_HAZARD_PERF_EN is defined; otherwise the perf ports read 0.
module pipe_hazard_ctrl
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter logic [31:0] TRAP_VECTOR  = TRAP_VECTOR_DEFAULT,
    parameter int unsigned DRAIN_CYCLES = 2
) (
    input  logic               clk,
    input  logic               rst,
    pipe_hazard_ctrl_if.slave  bus
);
    localparam logic [2:0] DRAIN_INIT = 3'(DRAIN_CYCLES - 1);

    state_e      state_reg, state_next;
    logic [2:0]  drain_reg, drain_next;
    logic [31:0] trap_pc_reg, trap_pc_next;
    logic        trap_enter;
    logic        load_use;
    logic        if_stall, if_flush, id_flush, ex_stall, ex_flush, pc_redirect;
    logic [31:0] pc_target;

    assign load_use = bus.id2ex_mem_rd && bus.id2ex_reg_wen && (bus.id2ex_reg_waddr != 5'd0) &&
                      (src_hit(bus.id_rs1_rd, bus.id_rs1_addr, bus.id2ex_reg_waddr) ||
                       src_hit(bus.id_rs2_rd, bus.id_rs2_addr, bus.id2ex_reg_waddr));

    always_comb begin
        state_next   = state_reg;
        drain_next   = drain_reg;
        trap_pc_next = trap_pc_reg;
        trap_enter   = 1'b0;
        if_stall     = 1'b0;
        if_flush     = 1'b0;
        id_flush     = 1'b0;
        ex_stall     = 1'b0;
        ex_flush     = 1'b0;
        pc_redirect  = 1'b0;
        pc_target    = '0;
        if (rst) begin
            state_next = ST_RUN;
        end else if (bus.mem_stall) begin
            // Hold everything; branch/trap decisions are taken once memory is ready.
            if_stall = 1'b1;
            ex_stall = 1'b1;
        end else begin
            unique case (state_reg)
                ST_RUN: begin
                    if (bus.ex_ill_instr) begin
                        if_flush     = 1'b1;
                        id_flush     = 1'b1;
                        ex_flush     = 1'b1;
                        trap_pc_next = bus.id2ex_pc;
                        drain_next   = DRAIN_INIT;
                        trap_enter   = 1'b1;
                        state_next   = ST_TRAP_DRAIN;
                    end else if (bus.ex_branch_taken) begin
                        pc_redirect = 1'b1;
                        pc_target   = bus.ex_branch_target;
                        if_flush    = 1'b1;
                        id_flush    = 1'b1;
                    end else if (bus.ex_mc_start) begin
                        state_next = ST_MC_WAIT;
                    end else if (load_use) begin
                        if_stall = 1'b1;
                        id_flush = 1'b1;
                    end
                end
                ST_MC_WAIT: begin
                    if (bus.ex_mc_done) begin
                        state_next = ST_RUN;
                    end else begin
                        if_stall = 1'b1;
                        ex_stall = 1'b1;
                    end
                end
                ST_TRAP_DRAIN: begin
                    if_flush = 1'b1;
                    id_flush = 1'b1;
                    ex_flush = 1'b1;
                    if (drain_reg == 3'd0)
                        state_next = ST_TRAP_REDIRECT;
                    else
                        drain_next = drain_reg - 3'd1;
                end
                ST_TRAP_REDIRECT: begin
                    pc_redirect = 1'b1;
                    pc_target   = TRAP_VECTOR;
                    if_flush    = 1'b1;
                    state_next  = ST_RUN;
                end
                default: state_next = ST_RUN;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= ST_RUN;
            drain_reg   <= '0;
            trap_pc_reg <= '0;
        end else begin
            state_reg   <= state_next;
            drain_reg   <= drain_next;
            trap_pc_reg <= trap_pc_next;
        end
    end

    assign bus.if_stall    = if_stall;
    assign bus.if_flush    = if_flush;
    assign bus.id_flush    = id_flush;
    assign bus.ex_stall    = ex_stall;
    assign bus.ex_flush    = ex_flush;
    assign bus.pc_redirect = pc_redirect;
    assign bus.pc_target   = pc_target;
    assign bus.trap_pc     = rst ? '0 : trap_pc_reg;
    assign bus.trap_active = !rst && ((state_reg == ST_TRAP_DRAIN) || (state_reg == ST_TRAP_REDIRECT));

`ifdef CORE_HAZARD_PERF_EN
    logic [31:0] stall_cnt, flush_cnt, trap_cnt;

    hazard_perf_cnt u_perf (
        .clk       (clk),
        .rst       (rst),
        .stall_evt (if_stall),
        .flush_evt (if_flush),
        .trap_evt  (trap_enter),
        .stall_cnt (stall_cnt),
        .flush_cnt (flush_cnt),
        .trap_cnt  (trap_cnt)
    );

    assign bus.perf_stall_cnt = rst ? '0 : stall_cnt;
    assign bus.perf_flush_cnt = rst ? '0 : flush_cnt;
    assign bus.perf_trap_cnt  = rst ? '0 : trap_cnt;
`else
    assign bus.perf_stall_cnt = '0;
    assign bus.perf_flush_cnt = '0;
    assign bus.perf_trap_cnt  = '0;
`endif
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl: directed test-plan scenarios followed by random traffic,
// predicted by a behavioural model of pending drain/redirect/multi-cycle work.
module tb_pipe_hazard_ctrl;
    localparam logic [31:0] TV    = 32'h0000_0004;
    localparam int          DRAIN = 2;
`ifdef CORE_HAZARD_PERF_EN
    localparam bit PERF_EN = 1'b1;
`else
    localparam bit PERF_EN = 1'b0;
`endif

    typedef struct {
        logic        rst;
        logic [4:0]  rs1, rs2, waddr;
        logic        rs1_rd, rs2_rd, wen, mem_rd;
        logic [31:0] pc;
        logic        ill, br;
        logic [31:0] tgt;
        logic        mc_start, mc_done, mem_stall;
    } stim_t;

    typedef struct {
        logic        if_stall, if_flush, id_flush, ex_stall, ex_flush, pc_redirect, trap_active;
        logic [31:0] pc_target, trap_pc, pst, pfl, ptr;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    pipe_hazard_ctrl_if bus();

    pipe_hazard_ctrl #(.TRAP_VECTOR(TV), .DRAIN_CYCLES(DRAIN)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int    checks = 0;
    int    errors = 0;
    int    cyc    = 0;
    exp_t  exp_q[$];
    stim_t cur;
    exp_t  cur_exp;

    // Model: outstanding work expressed as counts rather than controller states.
    bit          m_in_mc;
    int          m_drain_left;
    bit          m_redirect;
    logic [31:0] m_trap_pc, m_stall, m_flush, m_trap;

    function automatic stim_t idle();
        stim_t s;
        s = '{rst: 1'b0, rs1: 5'd0, rs2: 5'd0, waddr: 5'd0, rs1_rd: 1'b0, rs2_rd: 1'b0,
              wen: 1'b0, mem_rd: 1'b0, pc: 32'd0, ill: 1'b0, br: 1'b0, tgt: 32'd0,
              mc_start: 1'b0, mc_done: 1'b0, mem_stall: 1'b0};
        return s;
    endfunction

    function automatic exp_t predict(input stim_t s);
        exp_t e;
        bit   lu;
        e = '{if_stall: 1'b0, if_flush: 1'b0, id_flush: 1'b0, ex_stall: 1'b0, ex_flush: 1'b0,
              pc_redirect: 1'b0, trap_active: 1'b0, pc_target: 32'd0, trap_pc: 32'd0,
              pst: 32'd0, pfl: 32'd0, ptr: 32'd0};
        if (s.rst) return e;
        lu = s.mem_rd && s.wen && (s.waddr != 0) &&
             ((s.rs1_rd && s.rs1 == s.waddr) || (s.rs2_rd && s.rs2 == s.waddr));
        e.trap_pc     = m_trap_pc;
        e.trap_active = (m_drain_left > 0) || m_redirect;
        if (PERF_EN) begin
            e.pst = m_stall; e.pfl = m_flush; e.ptr = m_trap;
        end
        if (s.mem_stall) begin
            e.if_stall = 1; e.ex_stall = 1;
        end else if (m_drain_left > 0) begin
            e.if_flush = 1; e.id_flush = 1; e.ex_flush = 1;
        end else if (m_redirect) begin
            e.pc_redirect = 1; e.pc_target = TV; e.if_flush = 1;
        end else if (m_in_mc) begin
            if (!s.mc_done) begin e.if_stall = 1; e.ex_stall = 1; end
        end else if (s.ill) begin
            e.if_flush = 1; e.id_flush = 1; e.ex_flush = 1;
        end else if (s.br) begin
            e.pc_redirect = 1; e.pc_target = s.tgt; e.if_flush = 1; e.id_flush = 1;
        end else if (!s.mc_start && lu) begin
            e.if_stall = 1; e.id_flush = 1;
        end
        return e;
    endfunction

    task automatic model_update(input stim_t s, input exp_t e);
        if (s.rst) begin
            m_in_mc = 0; m_drain_left = 0; m_redirect = 0;
            m_trap_pc = 0; m_stall = 0; m_flush = 0; m_trap = 0;
        end else begin
            m_stall = m_stall + 32'(e.if_stall);
            m_flush = m_flush + 32'(e.if_flush);
            if (!s.mem_stall) begin
                if (m_drain_left > 0) begin
                    m_drain_left--;
                    if (m_drain_left == 0) m_redirect = 1;
                end else if (m_redirect) begin
                    m_redirect = 0;
                end else if (m_in_mc) begin
                    if (s.mc_done) m_in_mc = 0;
                end else if (s.ill) begin
                    m_trap_pc    = s.pc;
                    m_drain_left = DRAIN;
                    m_trap       = m_trap + 1;
                end else if (!s.br && s.mc_start) begin
                    m_in_mc = 1;
                end
            end
        end
    endtask

    task automatic apply(input stim_t s);
        rst                  = s.rst;
        bus.id_rs1_addr      = s.rs1;
        bus.id_rs1_rd        = s.rs1_rd;
        bus.id_rs2_addr      = s.rs2;
        bus.id_rs2_rd        = s.rs2_rd;
        bus.id2ex_reg_waddr  = s.waddr;
        bus.id2ex_reg_wen    = s.wen;
        bus.id2ex_mem_rd     = s.mem_rd;
        bus.id2ex_pc         = s.pc;
        bus.ex_ill_instr     = s.ill;
        bus.ex_branch_taken  = s.br;
        bus.ex_branch_target = s.tgt;
        bus.ex_mc_start      = s.mc_start;
        bus.ex_mc_done       = s.mc_done;
        bus.mem_stall        = s.mem_stall;
    endtask

    // One cycle: retire the inputs the DUT just clocked, then drive and predict the next set.
    task automatic step(input stim_t s);
        @(posedge clk);
        #1;
        model_update(cur, cur_exp);
        cur     = s;
        apply(cur);
        cur_exp = predict(cur);
        exp_q.push_back(cur_exp);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL cyc %0d %s: got %h expected %h", cyc, name, act, req);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                cyc++;
                chk("if_stall",    32'(bus.if_stall),    32'(e.if_stall));
                chk("if_flush",    32'(bus.if_flush),    32'(e.if_flush));
                chk("id_flush",    32'(bus.id_flush),    32'(e.id_flush));
                chk("ex_stall",    32'(bus.ex_stall),    32'(e.ex_stall));
                chk("ex_flush",    32'(bus.ex_flush),    32'(e.ex_flush));
                chk("pc_redirect", 32'(bus.pc_redirect), 32'(e.pc_redirect));
                chk("pc_target",   bus.pc_target,        e.pc_target);
                chk("trap_active", 32'(bus.trap_active), 32'(e.trap_active));
                chk("trap_pc",     bus.trap_pc,          e.trap_pc);
                chk("perf_stall",  bus.perf_stall_cnt,   e.pst);
                chk("perf_flush",  bus.perf_flush_cnt,   e.pfl);
                chk("perf_trap",   bus.perf_trap_cnt,    e.ptr);
                $display("cyc %0d rst=%0b st=%0b%0b fl=%0b%0b%0b rd=%0b tgt=%h ta=%0b tpc=%h",
                         cyc, rst, bus.if_stall, bus.ex_stall, bus.if_flush, bus.id_flush,
                         bus.ex_flush, bus.pc_redirect, bus.pc_target, bus.trap_active, bus.trap_pc);
            end
        end
    end

    initial begin : driver
        stim_t s;
        cur      = idle();
        cur.rst  = 1'b1;
        apply(cur);
        cur_exp  = predict(cur);
        s        = idle();
        s.rst    = 1'b1;
        repeat (3) step(s);

        // Load-use on x5, then the same pattern against x0.
        s = idle(); s.mem_rd = 1; s.wen = 1; s.waddr = 5'd5; s.rs1 = 5'd5; s.rs1_rd = 1;
        step(s); step(idle());
        s.waddr = 5'd0; s.rs1 = 5'd0;
        step(s); step(idle());

        // Taken branch to 0x100.
        s = idle(); s.br = 1; s.tgt = 32'h100;
        step(s); step(idle());

        // Illegal instruction at 0x40: drain, redirect, back to run.
        s = idle(); s.ill = 1; s.pc = 32'h40;
        step(s); repeat (4) step(idle());

        // Multi-cycle op with a same-cycle done that must be ignored.
        s = idle(); s.mc_start = 1; s.mc_done = 1;
        step(s); repeat (5) step(idle());
        s = idle(); s.mc_done = 1;
        step(s); step(idle());

        // mem_stall for 3 cycles in the middle of trap drain.
        s = idle(); s.ill = 1; s.pc = 32'h80;
        step(s); step(idle());
        s = idle(); s.mem_stall = 1;
        repeat (3) step(s);
        repeat (4) step(idle());

        // Reset while waiting on a multi-cycle op.
        s = idle(); s.mc_start = 1;
        step(s); step(idle());
        s = idle(); s.rst = 1;
        step(s); repeat (2) step(idle());

        for (int i = 0; i < 1500; i++) begin
            s.rst       = ($urandom_range(0, 199) == 0);
            s.rs1       = 5'($urandom_range(0, 3));
            s.rs2       = 5'($urandom_range(0, 3));
            s.waddr     = 5'($urandom_range(0, 3));
            s.rs1_rd    = 1'($urandom);
            s.rs2_rd    = 1'($urandom);
            s.wen       = ($urandom_range(0, 3) != 0);
            s.mem_rd    = 1'($urandom);
            s.pc        = $urandom;
            s.ill       = ($urandom_range(0, 24) == 0);
            s.br        = ($urandom_range(0, 7) == 0);
            s.tgt       = $urandom;
            s.mc_start  = ($urandom_range(0, 9) == 0);
            s.mc_done   = ($urandom_range(0, 3) == 0);
            s.mem_stall = ($urandom_range(0, 7) == 0);
            step(s);
        end

        @(negedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Central pipeline controller for the 5-stage core (IF, ID, EX, MEM, WB). It detects load-use hazards against the ID stage's decoded sources and sequences stalls, bubbles and flushes. It also handles taken-branch redirects, multi-cycle EX operations and the illegal-instruction trap entry sequence. It sits beside the datapath and drives the stall/flush inputs of the IF, ID and EX stages plus the PC redirect port.

## Interface
- TRAP_VECTOR, 32'h0000_0004, PC loaded on trap entry
- DRAIN_CYCLES, 2, cycles waited in TRAP_DRAIN for older instructions to retire (1..7)
- clk  in  1  clock
- rst  in  1  reset
- Reset `rst` is synchronous, active-high; clock is `clk`.
- id_rs1_addr  in  5  ID decoded rs1
- id_rs1_rd  in  1  ID instruction reads rs1
- id_rs2_addr  in  5  ID decoded rs2
- id_rs2_rd  in  1  ID instruction reads rs2
- id2ex_reg_waddr  in  5  EX-stage destination
- id2ex_reg_wen  in  1  EX-stage writes register
- id2ex_mem_rd  in  1  EX-stage instruction is a load
- id2ex_pc  in  32  EX-stage PC
- ex_ill_instr  in  1  EX-stage instruction is illegal
- ex_branch_taken  in  1  EX resolved taken branch/jump
- ex_branch_target  in  32  redirect target
- ex_mc_start  in  1  EX starts multi-cycle op
- ex_mc_done  in  1  multi-cycle op result ready
- mem_stall  in  1  data memory not ready
- if_stall  out  1  hold PC and IF/ID register
- if_flush  out  1  invalidate IF/ID register
- id_flush  out  1  ID emits bubble into EX
- ex_stall  out  1  hold ID/EX register
- ex_flush  out  1  EX emits bubble into MEM
- pc_redirect  out  1  load PC from pc_target
- pc_target  out  32  redirect PC
- trap_pc  out  32  captured PC of trapping instruction
- trap_active  out  1  FSM not in RUN/MC_WAIT
- perf_stall_cnt, perf_flush_cnt, perf_trap_cnt  out  32 each  performance counters

## Operation
- FSM states: RUN, MC_WAIT, TRAP_DRAIN, TRAP_REDIRECT.
- In RUN, priority is highest first:
  1. ex_ill_instr: ex_flush=id_flush=if_flush=1; trap_pc<=id2ex_pc; drain counter <= DRAIN_CYCLES-1; next state TRAP_DRAIN.
  2. ex_branch_taken: pc_redirect=1, pc_target=ex_branch_target, if_flush=id_flush=1.
  3. ex_mc_start: next state MC_WAIT.
  4. Load-use: fires when id2ex_mem_rd & id2ex_reg_wen & id2ex_reg_waddr!=0 & ((id_rs1_rd & rs1==waddr) | (id_rs2_rd & rs2==waddr)). Response: if_stall=1, id_flush=1 (one bubble).
- MC_WAIT: if_stall=ex_stall=1, id_flush=0. On ex_mc_done, return to RUN with no stall in that cycle.
- TRAP_DRAIN: if_flush=id_flush=ex_flush=1; decrement counter; at 0, next state TRAP_REDIRECT.
- TRAP_REDIRECT: pc_redirect=1, pc_target=TRAP_VECTOR, if_flush=1; next state RUN.
- mem_stall overrides everything: if_stall=ex_stall=1, all flushes and pc_redirect forced 0, and state and counter frozen. Exception: branch/trap decisions are re-evaluated when mem_stall drops.
- Register x0 never creates a hazard.

## Timing
- All control outputs are combinational from state and inputs. State, trap_pc, drain counter and perf counters are registered.
- Load-use costs exactly 1 bubble cycle.
- Branch penalty is 2 cycles (IF/ID and ID/EX killed).
- Trap entry: detection cycle, then DRAIN_CYCLES cycles, then 1 redirect cycle.
- Reset values:
  - state=RUN, trap_pc=0, counters=0.
  - All outputs 0 during and after reset until an input event.
- Reset mid-sequence (MC_WAIT/TRAP_*) returns to RUN next cycle with no redirect issued.
- ex_mc_done in the same cycle ex_mc_start is asserted is ignored.

## Configuration
- CORE_HAZARD_PERF_EN defined:
  - perf_stall_cnt increments each cycle if_stall=1.
  - perf_flush_cnt increments each cycle if_flush=1.
  - perf_trap_cnt increments on RUN->TRAP_DRAIN.
  - All counters wrap at 2^32.
- Not defined: the three perf ports are tied to 0, with no counter flops.

## Structure
- Shared package/header holds:
  - state encodings (2-bit: RUN=0, MC_WAIT=1, TRAP_DRAIN=2, TRAP_REDIRECT=3) and state range macro;
  - default TRAP_VECTOR constant.
- One sub-module, hazard_perf_cnt: the three counters, instantiated only under CORE_HAZARD_PERF_EN.

## Test plan
- Load x5 in EX, ID reads rs1=x5 -> if_stall=id_flush=1 for exactly 1 cycle; same with waddr=x0 -> no stall.
- ex_branch_taken with target 0x100 -> pc_redirect=1, pc_target=0x100, if_flush=id_flush=1 for one cycle, state stays RUN.
- ex_ill_instr with id2ex_pc=0x40, DRAIN_CYCLES=2 -> trap_pc=0x40; 2 drain cycles with all flushes; then pc_target=0x4 redirect; perf_trap_cnt=1.
- ex_mc_start, ex_mc_done after 5 cycles -> if_stall=ex_stall=1 for 5 cycles, then RUN.
- mem_stall held 3 cycles during TRAP_DRAIN -> counter frozen; redirect occurs 3 cycles late.
- rst asserted in MC_WAIT -> next cycle state RUN, all outputs 0, counters 0.
